// File: rtl/alu_pkg.sv
// Shared opcode and state encodings for the alu_seq datapath.
// ALU_MUL_EN selects whether the multiply state exists.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_ADDC = 4'd1,
        OP_SUB  = 4'd2,
        OP_SUBC = 4'd3,
        OP_CMP  = 4'd4,
        OP_AND  = 4'd5,
        OP_OR   = 4'd6,
        OP_XOR  = 4'd7,
        OP_TEST = 4'd8,
        OP_LSL  = 4'd9,
        OP_LSR  = 4'd10,
        OP_ROL  = 4'd11,
        OP_ROR  = 4'd12,
        OP_ASR  = 4'd13,
        OP_MOV  = 4'd14,
        OP_MUL  = 4'd15
    } alu_op_t;

`ifdef ALU_MUL_EN
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } alu_state_t;
`else
    typedef enum logic {
        ST_IDLE = 1'b0
    } alu_state_t;
`endif

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// WIDTH steps; the final step is folded combinationally into PROD at DONE.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               GO,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               DONE,
    output logic [2*WIDTH-1:0] PROD
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               run;

    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            run    <= 1'b0;
        end else if (GO) begin
            mcand  <= {{WIDTH{1'b0}}, A};
            mplier <= B;
            acc    <= '0;
            cnt    <= CW'(WIDTH - 1);
            run    <= 1'b1;
        end else if (run) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            if (cnt == '0) begin
                run <= 1'b0;
            end
        end
    end

    assign DONE = run && (cnt == '0);
    assign PROD = acc_next;

endmodule

// File: rtl/alu_seq.sv
// Registered RAT ALU with internal C/Z flags, one-deep flag shadow and an
// optional multi-cycle multiply enabled by the ALU_MUL_EN macro.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [3:0]       SEL,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             FLG_SAVE,
    input  logic             FLG_RESTORE,
    output logic [WIDTH-1:0] RESULT,
    output logic [WIDTH-1:0] RESULT_HI,
    output logic             C,
    output logic             Z,
    output logic             BUSY,
    output logic             VALID
);

    alu_op_t            op;
    logic               idle;
    logic               single;
    logic               mul_done;
    logic [2*WIDTH-1:0] prod;
    logic               sh_c;
    logic               sh_z;

    logic [WIDTH:0]     ax, bx, cinx, sum, diff;
    logic [WIDTH-1:0]   res;
    logic               c_new;
    logic               z_new;
    logic               wr_res;
    logic               wr_flg;

    assign op = alu_op_t'(SEL);

`ifdef ALU_MUL_EN
    alu_state_t state, state_next;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (START && op == OP_MUL) state_next = ST_MUL_RUN;
            ST_MUL_RUN: if (mul_done) state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        idle = (state == ST_IDLE);
        BUSY = (state == ST_MUL_RUN);
    end

    assign single = START && idle && (op != OP_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .CLK  (CLK),
        .RST  (RST),
        .GO   (START && idle && op == OP_MUL),
        .A    (A),
        .B    (B),
        .DONE (mul_done),
        .PROD (prod)
    );
`else
    // Without the multiplier SEL=15 falls through to the single-cycle path.
    assign idle     = 1'b1;
    assign BUSY     = 1'b0;
    assign single   = START;
    assign mul_done = 1'b0;
    assign prod     = '0;
`endif

    always_comb begin
        ax     = {1'b0, A};
        bx     = {1'b0, B};
        cinx   = {{WIDTH{1'b0}}, ((op == OP_ADDC || op == OP_SUBC) ? C : 1'b0)};
        sum    = ax + bx + cinx;
        diff   = ax - bx - cinx;
        res    = '0;
        c_new  = 1'b0;
        wr_res = 1'b1;
        wr_flg = 1'b1;
        case (op)
            OP_ADD, OP_ADDC: begin res = sum[WIDTH-1:0];  c_new = sum[WIDTH];  end
            OP_SUB, OP_SUBC: begin res = diff[WIDTH-1:0]; c_new = diff[WIDTH]; end
            OP_CMP:  begin res = diff[WIDTH-1:0]; c_new = diff[WIDTH]; wr_res = 1'b0; end
            OP_AND:  res = A & B;
            OP_OR:   res = A | B;
            OP_XOR:  res = A ^ B;
            OP_TEST: begin res = A & B; wr_res = 1'b0; end
            OP_LSL:  begin res = {A[WIDTH-2:0], 1'b0};      c_new = A[WIDTH-1]; end
            OP_LSR:  begin res = {1'b0, A[WIDTH-1:1]};      c_new = A[0];       end
            OP_ROL:  begin res = {A[WIDTH-2:0], C};         c_new = A[WIDTH-1]; end
            OP_ROR:  begin res = {C, A[WIDTH-1:1]};         c_new = A[0];       end
            OP_ASR:  begin res = {A[WIDTH-1], A[WIDTH-1:1]}; c_new = A[0];      end
            OP_MOV:  begin res = B;  wr_flg = 1'b0; end
            OP_MUL:  begin res = '0; wr_flg = 1'b0; end
        endcase
        z_new = (res == '0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            RESULT    <= '0;
            RESULT_HI <= '0;
            C         <= 1'b0;
            Z         <= 1'b0;
            sh_c      <= 1'b0;
            sh_z      <= 1'b0;
            VALID     <= 1'b0;
        end else begin
            VALID <= single || mul_done;
            if (single && wr_res) begin
                RESULT    <= res;
                RESULT_HI <= '0;
            end
            if (mul_done) begin
                RESULT    <= prod[WIDTH-1:0];
                RESULT_HI <= prod[2*WIDTH-1:WIDTH];
            end
            // Non-blocking update makes simultaneous save+restore a swap.
            if (FLG_SAVE) begin
                sh_c <= C;
                sh_z <= Z;
            end
            if (FLG_RESTORE) begin
                C <= sh_c;
                Z <= sh_z;
            end else if (mul_done) begin
                C <= |prod[2*WIDTH-1:WIDTH];
                Z <= (prod == '0);
            end else if (single && wr_flg) begin
                C <= c_new;
                Z <= z_new;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: an 8-bit instance for the op table, flags and
// multiply, a 16-bit instance for wide ROR and SEL=15; ALU_MUL_EN aware.
module tb_alu_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8, start8, save8, rest8;
    logic [3:0] sel8;
    logic [7:0] a8, b8, res8, hi8;
    logic       c8, z8, busy8, valid8;

    logic        rst16, start16, save16, rest16;
    logic [3:0]  sel16;
    logic [15:0] a16, b16, res16, hi16;
    logic        c16, z16, busy16, valid16;

    int n_cmp = 0;
    int n_bad = 0;

    alu_seq #(.WIDTH(8)) dut8 (
        .CLK(clk), .RST(rst8), .START(start8), .SEL(sel8), .A(a8), .B(b8),
        .FLG_SAVE(save8), .FLG_RESTORE(rest8), .RESULT(res8), .RESULT_HI(hi8),
        .C(c8), .Z(z8), .BUSY(busy8), .VALID(valid8)
    );

    alu_seq #(.WIDTH(16)) dut16 (
        .CLK(clk), .RST(rst16), .START(start16), .SEL(sel16), .A(a16), .B(b16),
        .FLG_SAVE(save16), .FLG_RESTORE(rest16), .RESULT(res16), .RESULT_HI(hi16),
        .C(c16), .Z(z16), .BUSY(busy16), .VALID(valid16)
    );

    typedef struct {
        alu_op_t    op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       c;
        logic       z;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step8(input logic st, input alu_op_t op, input logic [7:0] a,
                         input logic [7:0] b, input logic sv, input logic rs);
        start8 = st; sel8 = op; a8 = a; b8 = b; save8 = sv; rest8 = rs;
        @(posedge clk); #1;
        start8 = 1'b0; save8 = 1'b0; rest8 = 1'b0;
    endtask

    task automatic step16(input logic st, input alu_op_t op, input logic [15:0] a,
                          input logic [15:0] b);
        start16 = st; sel16 = op; a16 = a; b16 = b;
        @(posedge clk); #1;
        start16 = 1'b0;
    endtask

    task automatic flags8(input string name, input logic c, input logic z);
        chk(name, 32'({c8, z8}), 32'({c, z}));
    endtask

`ifdef ALU_MUL_EN
    // Idle-steps until VALID; cyc counts edges since the START edge.
    task automatic wait_valid8(inout int cyc);
        while (!valid8 && cyc < 40) begin
            chk("mul_busy", 32'(busy8), 1);
            step8(1'b0, OP_ADD, 8'h00, 8'h00, 1'b0, 1'b0);
            cyc++;
        end
    endtask
`endif

    initial begin
        int cyc;
        int pulses;
        rst8 = 1'b1; start8 = 1'b0; save8 = 1'b0; rest8 = 1'b0; sel8 = '0; a8 = '0; b8 = '0;
        rst16 = 1'b1; start16 = 1'b0; save16 = 1'b0; rest16 = 1'b0; sel16 = '0; a16 = '0; b16 = '0;

        tbl.push_back('{OP_LSL,  8'h80, 8'h00, 8'h00, 1'b1, 1'b1});
        tbl.push_back('{OP_ADDC, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1});
        tbl.push_back('{OP_SUB,  8'h10, 8'h20, 8'hF0, 1'b1, 1'b0});
        tbl.push_back('{OP_CMP,  8'h20, 8'h20, 8'hF0, 1'b0, 1'b1});
        tbl.push_back('{OP_ADD,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b0});
        tbl.push_back('{OP_ADD,  8'hFF, 8'h02, 8'h01, 1'b1, 1'b0});
        tbl.push_back('{OP_SUBC, 8'h05, 8'h04, 8'h00, 1'b0, 1'b1});
        tbl.push_back('{OP_AND,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0});
        tbl.push_back('{OP_OR,   8'h00, 8'h00, 8'h00, 1'b0, 1'b1});
        tbl.push_back('{OP_XOR,  8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0});
        tbl.push_back('{OP_TEST, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b1});
        tbl.push_back('{OP_LSR,  8'h01, 8'h00, 8'h00, 1'b1, 1'b1});
        tbl.push_back('{OP_ROL,  8'h80, 8'h00, 8'h01, 1'b1, 1'b0});
        tbl.push_back('{OP_ROR,  8'h02, 8'h00, 8'h81, 1'b0, 1'b0});
        tbl.push_back('{OP_ASR,  8'h81, 8'h00, 8'hC0, 1'b1, 1'b0});
        tbl.push_back('{OP_MOV,  8'h00, 8'h3C, 8'h3C, 1'b1, 1'b0});
        tbl.push_back('{OP_ROL,  8'h00, 8'h00, 8'h01, 1'b0, 1'b0});
        tbl.push_back('{OP_ASR,  8'h01, 8'h00, 8'h00, 1'b1, 1'b1});
        tbl.push_back('{OP_MOV,  8'h00, 8'h00, 8'h00, 1'b1, 1'b1});
        tbl.push_back('{OP_SUBC, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0});
        tbl.push_back('{OP_ADDC, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0});

        @(posedge clk); #1;
        rst8 = 1'b0; rst16 = 1'b0;
        chk("rst_result", 32'(res8), 0);
        chk("rst_hi", 32'(hi8), 0);
        flags8("rst_flags", 1'b0, 1'b0);
        chk("rst_busy_valid", 32'({busy8, valid8}), 0);

        // Back-to-back single-cycle ops; each must pulse VALID.
        foreach (tbl[i]) begin
            step8(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, 1'b0);
            chk($sformatf("vec%0d_result", i), 32'(res8), 32'(tbl[i].res));
            chk($sformatf("vec%0d_flags", i), 32'({c8, z8}), 32'({tbl[i].c, tbl[i].z}));
            chk($sformatf("vec%0d_valid", i), 32'(valid8), 1);
            chk($sformatf("vec%0d_hi_busy", i), 32'({hi8, busy8}), 0);
        end
        step8(1'b0, OP_ADD, 8'h11, 8'h22, 1'b0, 1'b0);
        chk("idle_valid", 32'(valid8), 0);
        chk("idle_result", 32'(res8), 'h01);

        // Flag shadow.
        step8(1'b1, OP_LSL, 8'hC0, 8'h00, 1'b0, 1'b0);
        flags8("lsl_c0", 1'b1, 1'b0);
        step8(1'b0, OP_ADD, 8'h00, 8'h00, 1'b1, 1'b0);
        flags8("save_only", 1'b1, 1'b0);
        step8(1'b1, OP_XOR, 8'h5A, 8'h5A, 1'b0, 1'b0);
        flags8("xor_5a", 1'b0, 1'b1);
        step8(1'b0, OP_ADD, 8'h00, 8'h00, 1'b0, 1'b1);
        flags8("restore", 1'b1, 1'b0);
        step8(1'b1, OP_XOR, 8'h5A, 8'h5A, 1'b0, 1'b0);
        step8(1'b0, OP_ADD, 8'h00, 8'h00, 1'b1, 1'b1);
        flags8("swap_flags", 1'b1, 1'b0);
        step8(1'b0, OP_ADD, 8'h00, 8'h00, 1'b0, 1'b1);
        flags8("swap_shadow", 1'b0, 1'b1);
        step8(1'b1, OP_ADD, 8'hFF, 8'hFF, 1'b0, 1'b1);
        flags8("restore_vs_add", 1'b0, 1'b1);
        chk("restore_add_result", 32'(res8), 'hFE);
        chk("restore_add_valid", 32'(valid8), 1);

`ifdef ALU_MUL_EN
        // 0xFF*0xFF with operands changed after START and a dropped START.
        step8(1'b1, OP_MUL, 8'hFF, 8'hFF, 1'b0, 1'b0);
        a8 = 8'h12; b8 = 8'h34;
        chk("mul_busy_rise", 32'({busy8, valid8}), 'b10);
        cyc = 1;
        chk("mul_busy", 32'(busy8), 1);
        step8(1'b1, OP_ADD, 8'h01, 8'h01, 1'b0, 1'b0);
        cyc = 2;
        wait_valid8(cyc);
        chk("mul_latency", cyc, 8);
        chk("mul_ff_lo", 32'(res8), 'h01);
        chk("mul_ff_hi", 32'(hi8), 'hFE);
        flags8("mul_ff_flags", 1'b1, 1'b0);
        chk("mul_ff_busy", 32'(busy8), 0);
        step8(1'b0, OP_ADD, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("mul_valid_pulse", 32'(valid8), 0);
        chk("mul_drop_result", 32'(res8), 'h01);

        step8(1'b1, OP_MUL, 8'h00, 8'h37, 1'b0, 1'b0);
        cyc = 1;
        wait_valid8(cyc);
        chk("mul_zero_latency", cyc, 8);
        chk("mul_zero_prod", 32'({hi8, res8}), 0);
        flags8("mul_zero_flags", 1'b0, 1'b1);

        // Abort a multiply with reset in its fourth BUSY cycle.
        step8(1'b1, OP_LSL, 8'hC0, 8'h00, 1'b0, 1'b0);
        step8(1'b1, OP_MUL, 8'hFF, 8'hFF, 1'b0, 1'b0);
        repeat (3) step8(1'b0, OP_ADD, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("abort_pre_busy", 32'(busy8), 1);
        rst8 = 1'b1;
        step8(1'b0, OP_ADD, 8'h00, 8'h00, 1'b0, 1'b0);
        rst8 = 1'b0;
        chk("abort_busy_valid", 32'({busy8, valid8}), 0);
        chk("abort_outputs", 32'({hi8, res8, c8, z8}), 0);
        pulses = 0;
        repeat (10) begin
            step8(1'b0, OP_ADD, 8'h00, 8'h00, 1'b0, 1'b0);
            if (valid8 || busy8) pulses++;
        end
        chk("abort_no_valid", pulses, 0);
`else
        step8(1'b1, OP_MOV, 8'h00, 8'h5C, 1'b0, 1'b0);
        step8(1'b1, OP_MUL, 8'h12, 8'h34, 1'b0, 1'b0);
        chk("nomul8_valid_busy", 32'({valid8, busy8}), 'b10);
        chk("nomul8_prod", 32'({hi8, res8}), 0);
        flags8("nomul8_flags", 1'b0, 1'b1);
`endif

        // 16-bit instance.
        chk("rst16_outputs", 32'({res16, c16, z16, busy16, valid16}), 0);
        step16(1'b1, OP_LSL, 16'h8000, 16'h0000);
        chk("w16_lsl", 32'({res16, c16, z16}), 32'({16'h0000, 2'b11}));
        step16(1'b1, OP_ROR, 16'h0001, 16'h0000);
        chk("w16_ror", 32'({res16, c16, z16}), 32'({16'h8000, 2'b10}));
        step16(1'b1, OP_MUL, 16'h1234, 16'h0002);
`ifdef ALU_MUL_EN
        cyc = 1;
        while (!valid16 && cyc < 60) begin
            chk("w16_mul_busy", 32'(busy16), 1);
            step16(1'b0, OP_ADD, 16'h0000, 16'h0000);
            cyc++;
        end
        chk("w16_mul_latency", cyc, 16);
        chk("w16_mul_prod", {hi16, res16}, 32'h0000_2468);
        chk("w16_mul_flags", 32'({c16, z16}), 0);
`else
        chk("w16_nomul_valid", 32'(valid16), 1);
        chk("w16_nomul_prod", {hi16, res16}, 0);
        chk("w16_nomul_flags", 32'({c16, z16}), 'b10);
        pulses = 0;
        if (busy16) pulses++;
        repeat (20) begin
            step16(1'b0, OP_ADD, 16'h0000, 16'h0000);
            if (busy16) pulses++;
        end
        chk("w16_nomul_busy", pulses, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the RAT datapath ALU. Executes one of 16 operations on WIDTH-bit operands, holds the C and Z flags internally (CIN is taken from the internal C flag), provides a one-deep flag shadow for interrupt entry and return, and adds an iterative multi-cycle multiply with a BUSY/VALID handshake. It sits between the register file and the result mux of the RAT CPU, and the control unit sequences it.

## Interface
- WIDTH, 8, operand/result width (≥2)
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- START  in  1  execute SEL on A/B this cycle; ignored while BUSY
- SEL  in  4  opcode (alu_op_t)
- A, B  in  WIDTH  operands
- FLG_SAVE  in  1  copy C,Z into shadow
- FLG_RESTORE  in  1  load C,Z from shadow
- RESULT  out  WIDTH  registered result (low half for MUL)
- RESULT_HI  out  WIDTH  registered high half of MUL product; 0 for other ops
- C, Z  out  1  registered flags
- BUSY  out  1  multiply in progress
- VALID  out  1  one-cycle pulse: RESULT/flags updated

## Operation
- Opcodes: 0 ADD, 1 ADDC, 2 SUB, 3 SUBC, 4 CMP, 5 AND, 6 OR, 7 XOR, 8 TEST, 9 LSL, 10 LSR, 11 ROL, 12 ROR, 13 ASR, 14 MOV, 15 MUL.
- Arithmetic in WIDTH+1 bits. ADD/ADDC: C = carry out. SUB/SUBC/CMP: C = borrow (A < B + cin). ADDC/SUBC use the current C flag as cin.
- AND/OR/XOR/TEST: C = 0. CMP and TEST update flags only; RESULT holds its previous value.
- LSL: {A[W-2:0],0}, C = A[W-1]. LSR: {0,A[W-1:1]}, C = A[0]. ROL: {A[W-2:0],C}, C = A[W-1]. ROR: {C,A[W-1:1]}, C = A[0]. ASR: {A[W-1],A[W-1:1]}, C = A[0].
- MOV: RESULT = B; flags unchanged.
- Z = (WIDTH-bit result == 0) for all flag-setting ops. For MUL, Z = (full 2·WIDTH product == 0) and C = (RESULT_HI != 0).
- MUL: shift-add, unsigned, WIDTH iterations. Operands are latched at START, and A/B may change afterwards.
- States: IDLE, MUL_RUN. IDLE + START + SEL=15 → MUL_RUN with iteration counter = WIDTH-1. MUL_RUN decrements each cycle; at 0 it writes the results, pulses VALID, and returns to IDLE.
- Flag priority per edge: RST > FLG_RESTORE > op flag update.
- FLG_SAVE samples the pre-edge C,Z. SAVE and RESTORE in the same cycle swap flags and shadow.

## Timing
- Reset values: RESULT = 0, RESULT_HI = 0, C = 0, Z = 0, shadow = 0, BUSY = 0, VALID = 0, state = IDLE.
- Single-cycle ops: START sampled at edge n; RESULT, flags and VALID are visible after edge n. VALID lasts one cycle. Back-to-back STARTs give back-to-back VALIDs.
- MUL: BUSY rises after edge n and stays high for WIDTH cycles. VALID is high in the cycle BUSY falls. Latency is WIDTH cycles from the START edge.
- START while BUSY is dropped: no queueing, no VALID.
- RST during MUL_RUN aborts the multiply: BUSY = 0 next cycle, no VALID, all state reset.
- FLG_RESTORE in the same cycle as a flag-setting op: restored flags win, and RESULT still updates.

## Configuration
- ALU_MUL_EN defined: MUL implemented as above.
- ALU_MUL_EN undefined:
  - SEL=15 is single-cycle: RESULT and RESULT_HI are set to 0, flags unchanged, VALID pulses.
  - BUSY is tied to 0 and MUL_RUN does not exist.

## Structure
- Package alu_pkg holds:
  - typedef enum logic [3:0] alu_op_t, with the opcodes above.
  - The state enum alu_state_t.
- Sub-module alu_mul_iter contains the shift-add datapath plus its counter.
- It has ports CLK, RST, GO, A, B, DONE, PROD, and is instantiated only under ALU_MUL_EN.

## Test plan
- Reset, then ADDC with C=1 (set via LSL of A=0x80), A=0xFF, B=0x00 → RESULT=0x00, C=1, Z=1, VALID one cycle.
- SUB A=0x10, B=0x20 → RESULT=0xF0, C=1, Z=0. Then CMP A=0x20, B=0x20 → Z=1, C=0, RESULT still 0xF0.
- MUL 0xFF×0xFF (WIDTH=8) → after 8 BUSY cycles RESULT=0x01, RESULT_HI=0xFE, C=1, Z=0. START during BUSY is ignored.
- MUL 0x00×0x37 → RESULT=0, RESULT_HI=0, Z=1, C=0. Assert RST at BUSY cycle 4 in a repeat run → BUSY=0, no VALID, all outputs 0.
- Set C=1,Z=0, FLG_SAVE; XOR A=B=0x5A (C=0,Z=1); FLG_RESTORE → C=1, Z=0. Same-cycle SAVE+RESTORE swaps.
- Build with ALU_MUL_EN undefined, WIDTH=16: SEL=15 → VALID next cycle, RESULT=0, BUSY never high. ROR A=0x0001 with C=1 → 0x8000, C=1.
